// File: rtl/conv2d_pkg.sv
// Shared types and constant helpers for the conv2d pixel source.
package conv2d_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_e;

  localparam int unsigned PIXEL_BITS_DEF = 8;

  // Dimension of the frame including the border on both sides.
  function automatic int unsigned padded_dim(input int unsigned dim, input int unsigned pad);
    return dim + 2 * pad;
  endfunction

  // Counter width able to hold every padded position plus one.
  function automatic int unsigned cnt_bits(input int unsigned dim, input int unsigned pad);
    return $clog2(dim + 2 * pad + 1);
  endfunction

endpackage

// File: rtl/pixel_stream_tx_if.sv
// Frame-buffer read port, control handshake and pixel output stream.
interface pixel_stream_tx_if
  import conv2d_pkg::*;
#(
  parameter int unsigned PIXEL_BITS = PIXEL_BITS_DEF,
  parameter int unsigned ADDR_BITS  = 14
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  mem_rd_en;
  logic [ADDR_BITS-1:0]  mem_addr;
  logic [PIXEL_BITS-1:0] mem_rdata;
  logic [PIXEL_BITS-1:0] pixel_out;
  logic                  pixel_valid;
  logic                  out_ready;
  logic                  sof;
  logic                  eol;

  modport master (
    input  start, mem_rdata, out_ready,
    output busy, done, mem_rd_en, mem_addr, pixel_out, pixel_valid, sof, eol
  );

  modport slave (
    output start, mem_rdata, out_ready,
    input  busy, done, mem_rd_en, mem_addr, pixel_out, pixel_valid, sof, eol
  );
endinterface

// File: rtl/pix_skid_buf.sv
// Two-entry valid/ready buffer; head entry drives the output directly.
module pix_skid_buf #(
  parameter int unsigned DW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  input  logic          out_ready_i,
  output logic [1:0]    occ_o
);
  logic [DW-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          pop;

  assign pop = (cnt_q != 2'd0) && out_ready_i;

  // Push/pop bookkeeping; a drained head is cleared so stale markers never linger.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({pop, in_valid_i})
      2'b01: begin
        if (cnt_q == 2'd0) head_d = in_data_i;
        else               tail_d = in_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b10: begin
        head_d = (cnt_q == 2'd2) ? tail_q : '0;
        tail_d = '0;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = in_data_i;
        end else begin
          head_d = in_data_i;
        end
      end
      default: ;
    endcase
  end

  // Storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = head_q;
  assign occ_o       = cnt_q;
endmodule

// File: rtl/pixel_stream_tx.sv
// Raster pixel source: reads a frame from 1-cycle RAM and emits it with a padded border.
module pixel_stream_tx
  import conv2d_pkg::*;
#(
  parameter int unsigned          IMG_W      = 128,
  parameter int unsigned          IMG_H      = 128,
  parameter int unsigned          PIXEL_BITS = PIXEL_BITS_DEF,
  parameter int unsigned          PAD        = 1,
  parameter logic [PIXEL_BITS-1:0] PAD_VALUE = '0,
  parameter int unsigned          ADDR_BITS  = $clog2(IMG_W * IMG_H)
) (
  input  logic               clk,
  input  logic               rst,
  pixel_stream_tx_if.master  bus
);
  localparam int unsigned PW = padded_dim(IMG_W, PAD);
  localparam int unsigned PH = padded_dim(IMG_H, PAD);
  localparam int unsigned CW = cnt_bits(IMG_W, PAD);
  localparam int unsigned RW = cnt_bits(IMG_H, PAD);
  localparam int unsigned DW = PIXEL_BITS + 2;

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        pc_q, pc_d;
  logic [RW-1:0]        pr_q, pr_d;
  logic [ADDR_BITS-1:0] row_base_q, row_base_d;
  logic                 done_q, done_d, busy_q, busy_d;
  logic                 infl_q, infl_pad_q, infl_sof_q, infl_eol_q;

  logic [CW-1:0]        col_off;
  logic [RW-1:0]        row_off;
  logic                 interior, last_col, last_row, issue, pop, sk_valid;
  logic [1:0]           occ, occ_eff;
  logic [DW-1:0]        sk_in, sk_out;

  // Border offsets wrap to large values, so one unsigned compare covers both edges.
  assign col_off  = pc_q - CW'(PAD);
  assign row_off  = pr_q - RW'(PAD);
  assign interior = (col_off < CW'(IMG_W)) && (row_off < RW'(IMG_H));
  assign last_col = (pc_q == CW'(PW - 1));
  assign last_row = (pr_q == RW'(PH - 1));

  // Issue one position when the buffer can absorb it after this cycle's pop.
  always_comb begin
    pop           = sk_valid && bus.out_ready;
    occ_eff       = occ - 2'(pop);
    issue         = (state_q == ST_RUN) && ((occ_eff + 2'(infl_q)) < 2'd2);
    bus.mem_rd_en = issue && interior;
    bus.mem_addr  = bus.mem_rd_en ? (row_base_q + ADDR_BITS'(col_off)) : '0;
  end

  // Next-state, raster counters and running row base.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pr_d       = pr_q;
    row_base_d = row_base_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_RUN;
          pc_d       = '0;
          pr_d       = '0;
          row_base_d = '0;
        end
      end
      ST_RUN: begin
        if (issue) begin
          if (last_col) begin
            pc_d = '0;
            if (row_off < RW'(IMG_H)) row_base_d = row_base_q + ADDR_BITS'(IMG_W);
            if (last_row) begin
              pr_d    = '0;
              state_d = ST_DRAIN;
            end else begin
              pr_d = pr_q + RW'(1);
            end
          end else begin
            pc_d = pc_q + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if ((occ == 2'd0) && !infl_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE) || done_d;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      pr_q       <= '0;
      row_base_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pr_q       <= pr_d;
      row_base_q <= row_base_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  // In-flight tag for the position whose RAM data arrives next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_q     <= 1'b0;
      infl_pad_q <= 1'b0;
      infl_sof_q <= 1'b0;
      infl_eol_q <= 1'b0;
    end else begin
      infl_q <= issue;
      if (issue) begin
        infl_pad_q <= !interior;
        infl_sof_q <= (pc_q == '0) && (pr_q == '0);
        infl_eol_q <= last_col;
      end
    end
  end

  assign sk_in = {(infl_pad_q ? PAD_VALUE : bus.mem_rdata), infl_sof_q, infl_eol_q};

  pix_skid_buf #(.DW(DW)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (infl_q),
    .in_data_i   (sk_in),
    .out_valid_o (sk_valid),
    .out_data_o  (sk_out),
    .out_ready_i (bus.out_ready),
    .occ_o       (occ)
  );

  assign bus.pixel_valid = sk_valid;
  assign bus.pixel_out   = sk_out[DW-1:2];
  assign bus.sof         = sk_out[1];
  assign bus.eol         = sk_out[0];
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_pixel_stream_tx.sv
// Bench for pixel_stream_tx: a padded (PAD=1) and an unpadded (PAD=0) instance share one RAM image.
module tb_pixel_stream_tx;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned AB = 4;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b, ready;
  always #5 clk = ~clk;

  pixel_stream_tx_if #(.PIXEL_BITS(8), .ADDR_BITS(AB)) ia ();
  pixel_stream_tx_if #(.PIXEL_BITS(8), .ADDR_BITS(AB)) ib ();

  pixel_stream_tx #(.IMG_W(W), .IMG_H(H), .PIXEL_BITS(8), .PAD(1), .PAD_VALUE(8'h00),
                    .ADDR_BITS(AB)) dut_a (.clk(clk), .rst(rst), .bus(ia.master));
  pixel_stream_tx #(.IMG_W(W), .IMG_H(H), .PIXEL_BITS(8), .PAD(0), .PAD_VALUE(8'h00),
                    .ADDR_BITS(AB)) dut_b (.clk(clk), .rst(rst), .bus(ib.master));

  // Frame buffer model with 1-cycle read latency and read counters.
  logic [7:0] ram [0:15];
  logic [7:0] rda, rdb;
  int rd_a = 0, rd_b = 0;
  always @(posedge clk) begin
    if (ia.mem_rd_en) begin rda <= ram[ia.mem_addr]; rd_a <= rd_a + 1; end
    if (ib.mem_rd_en) begin rdb <= ram[ib.mem_addr]; rd_b <= rd_b + 1; end
  end

  assign ia.start = start_a;  assign ib.start = start_b;
  assign ia.out_ready = ready; assign ib.out_ready = ready;
  assign ia.mem_rdata = rda;  assign ib.mem_rdata = rdb;

  int nchk = 0, nfail = 0, cyc = 0;
  logic [9:0] expv [2][64];
  int nexp[2], nbeat[2], ndone[2], since_acc[2], first_acc[2], last_acc[2];
  bit stall[2], act[2];
  logic [9:0] hold[2];
  int rda0, rdb0, start_cyc;

  typedef struct {
    int mode; bit restart; bit rand_ram; int beats_a; int beats_b; int reads;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input bit ok, input string nm, input int d, input int got, input int want);
    nchk++;
    if (!ok) begin
      nfail++;
      $display("FAIL %s[%0d]: got %0d want %0d", nm, d, got, want);
    end
  endtask

  // Expected padded raster stream derived from the image and border width.
  task automatic build(input int d, input int pad);
    int pw, ph, n;
    bit in_img;
    logic [7:0] px;
    pw = W + 2 * pad; ph = H + 2 * pad; n = 0;
    for (int r = 0; r < ph; r++)
      for (int c = 0; c < pw; c++) begin
        in_img = (r >= pad) && (r < H + pad) && (c >= pad) && (c < W + pad);
        px = in_img ? ram[4'((r - pad) * W + (c - pad))] : 8'h00;
        expv[d][n] = {px, 1'(r == 0 && c == 0), 1'(c == pw - 1)};
        n++;
      end
    nexp[d] = n;
  endtask

  task automatic mon(input int d, input logic v, input logic [7:0] p, input logic s,
                     input logic e, input logic dn, input logic bz);
    logic [9:0] cur;
    cur = {p, s, e};
    if (stall[d]) chk(v && cur == hold[d], "stall_hold", d, int'(cur), int'(hold[d]));
    if (act[d]) chk(bz == 1'b1, "busy_in_frame", d, int'(bz), 1);
    since_acc[d]++;
    if (dn) begin
      ndone[d]++;
      chk(nbeat[d] == nexp[d] && since_acc[d] == 2, "done_timing", d, since_acc[d], 2);
      act[d] = 1'b0;
    end
    if (v && ready) begin
      if (nbeat[d] >= nexp[d]) chk(1'b0, "extra_beat", d, int'(cur), 0);
      else chk(cur == expv[d][nbeat[d]], "beat", d, int'(cur), int'(expv[d][nbeat[d]]));
      if (nbeat[d] == 0) first_acc[d] = cyc;
      last_acc[d] = cyc;
      nbeat[d]++;
      since_acc[d] = 0;
    end
    stall[d] = v && !ready;
    hold[d]  = cur;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (rst) begin
      stall[0] = 1'b0; stall[1] = 1'b0;
    end else begin
      mon(0, ia.pixel_valid, ia.pixel_out, ia.sof, ia.eol, ia.done, ia.busy);
      mon(1, ib.pixel_valid, ib.pixel_out, ib.sof, ib.eol, ib.done, ib.busy);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
    return ($urandom_range(0, 3) != 0);
  endfunction

  function automatic int outs_a();
    return 32'({ia.busy, ia.done, ia.mem_rd_en, ia.mem_addr, ia.pixel_out, ia.pixel_valid, ia.sof, ia.eol});
  endfunction
  function automatic int outs_b();
    return 32'({ib.busy, ib.done, ib.mem_rd_en, ib.mem_addr, ib.pixel_out, ib.pixel_valid, ib.sof, ib.eol});
  endfunction

  task automatic start_frame();
    build(0, 1); build(1, 0);
    for (int d = 0; d < 2; d++) begin
      nbeat[d] = 0; ndone[d] = 0; stall[d] = 1'b0; act[d] = 1'b0;
      since_acc[d] = 100; first_acc[d] = 0; last_acc[d] = 0;
    end
    rda0 = rd_a; rdb0 = rd_b;
    start_a = 1'b1; start_b = 1'b1;
    step();
    start_a = 1'b0; start_b = 1'b0;
    start_cyc = cyc;
    act[0] = 1'b1; act[1] = 1'b1;
  endtask

  task automatic finish_frame(input int mode, input bit restart, input int budget);
    bit pa3, pa20, pb3, pb8;
    int k;
    pa3 = 0; pa20 = 0; pb3 = 0; pb8 = 0; k = 0;
    while (!(ndone[0] > 0 && ndone[1] > 0) && k < budget) begin
      ready = pick(mode, k);
      start_a = 1'b0; start_b = 1'b0;
      if (restart) begin
        if (nbeat[0] == 3  && !pa3)  begin start_a = 1'b1; pa3  = 1; end
        if (nbeat[0] == 20 && !pa20) begin start_a = 1'b1; pa20 = 1; end
        if (nbeat[1] == 3  && !pb3)  begin start_b = 1'b1; pb3  = 1; end
        if (nbeat[1] == 8  && !pb8)  begin start_b = 1'b1; pb8  = 1; end
      end
      step();
      k++;
    end
    start_a = 1'b0; start_b = 1'b0;
    chk(ndone[0] > 0, "done_seen", 0, ndone[0], 1);
    chk(ndone[1] > 0, "done_seen", 1, ndone[1], 1);
    ready = 1'b1;
    repeat (3) step();
    chk(ndone[0] == 1, "single_done", 0, ndone[0], 1);
    chk(ndone[1] == 1, "single_done", 1, ndone[1], 1);
    chk(!ia.busy, "busy_after", 0, int'(ia.busy), 0);
    chk(!ib.busy, "busy_after", 1, int'(ib.busy), 0);
  endtask

  initial begin
    tbl[0] = '{0, 1'b0, 1'b0, 30, 12, 12};
    tbl[1] = '{1, 1'b0, 1'b0, 30, 12, 12};
    tbl[2] = '{0, 1'b1, 1'b0, 30, 12, 12};
    tbl[3] = '{2, 1'b0, 1'b1, 30, 12, 12};
    tbl[4] = '{2, 1'b1, 1'b1, 30, 12, 12};
    for (int i = 0; i < 16; i++) ram[i] = 8'(i + 1);

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(outs_a() == 0, "reset_outs", 0, outs_a(), 0);
    chk(outs_b() == 0, "reset_outs", 1, outs_b(), 0);
    rst = 1'b0;
    step();

    // Frame scenarios: ready pattern, spurious starts, image contents.
    for (int t = 0; t < 5; t++) begin
      if (tbl[t].rand_ram) for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
      else                 for (int i = 0; i < 16; i++) ram[i] = 8'(i + 1);
      ready = pick(tbl[t].mode, 0);
      start_frame();
      finish_frame(tbl[t].mode, tbl[t].restart, 500);
      chk(nbeat[0] == tbl[t].beats_a, "beat_count", 0, nbeat[0], tbl[t].beats_a);
      chk(nbeat[1] == tbl[t].beats_b, "beat_count", 1, nbeat[1], tbl[t].beats_b);
      chk(rd_a - rda0 == tbl[t].reads, "ram_reads", 0, rd_a - rda0, tbl[t].reads);
      chk(rd_b - rdb0 == tbl[t].reads, "ram_reads", 1, rd_b - rdb0, tbl[t].reads);
      if (tbl[t].mode == 0) begin
        chk(first_acc[0] - start_cyc == 3, "first_latency", 0, first_acc[0] - start_cyc, 3);
        chk(first_acc[1] - start_cyc == 3, "first_latency", 1, first_acc[1] - start_cyc, 3);
        chk(last_acc[0] - first_acc[0] == 29, "full_rate", 0, last_acc[0] - first_acc[0], 29);
        chk(last_acc[1] - first_acc[1] == 11, "full_rate", 1, last_acc[1] - first_acc[1], 11);
      end
    end

    for (int i = 0; i < 16; i++) ram[i] = 8'(i + 1);

    // Ready low from start: only two positions may be issued before stalling.
    ready = 1'b0;
    start_frame();
    repeat (8) step();
    chk(rd_b - rdb0 == 2, "stall_reads", 1, rd_b - rdb0, 2);
    chk(rd_a - rda0 == 0, "stall_reads", 0, rd_a - rda0, 0);
    chk(ia.pixel_valid && ib.pixel_valid, "stall_valid", 0,
        int'({ia.pixel_valid, ib.pixel_valid}), 3);
    finish_frame(0, 1'b0, 200);
    chk(nbeat[0] == 30 && nbeat[1] == 12, "resume_beats", 0, nbeat[0] * 100 + nbeat[1], 3012);

    // Reset mid-frame while stalled, then a clean frame.
    ready = 1'b1;
    start_frame();
    for (int k = 0; k < 100 && nbeat[0] < 10; k++) step();
    ready = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk(outs_a() == 0, "abort_outs", 0, outs_a(), 0);
    chk(outs_b() == 0, "abort_outs", 1, outs_b(), 0);
    repeat (2) step();
    rst = 1'b0;
    act[0] = 1'b0; act[1] = 1'b0;
    ready = 1'b1;
    repeat (4) step();
    chk(ndone[0] == 0 && ndone[1] == 0, "abort_no_done", 0, ndone[0] + ndone[1], 0);
    chk(!ia.busy && !ib.busy, "abort_idle", 0, int'({ia.busy, ib.busy}), 0);
    start_frame();
    finish_frame(0, 1'b0, 200);
    chk(nbeat[0] == 30, "post_reset_beats", 0, nbeat[0], 30);
    chk(nbeat[1] == 12, "post_reset_beats", 1, nbeat[1], 12);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
